// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared widths, memory-size encoding and load-path packet types
package sys_defs;

    localparam int XLEN        = 32;
    localparam int ROB_TAG_LEN = 5;
    localparam int ACU_DEPTH   = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } MEM_SIZE;

    typedef struct packed {
        logic                   valid;
        logic [XLEN-1:0]        address;
        logic [ROB_TAG_LEN-1:0] rd_tag;
        MEM_SIZE                mem_size;
    } LB_PACKET;

    typedef struct packed {
        logic                   valid;
        logic                   base_ready;
        logic [XLEN-1:0]        base_value;
        logic [ROB_TAG_LEN-1:0] base_tag;
        logic [XLEN-1:0]        imm;
        logic [ROB_TAG_LEN-1:0] rd_tag;
        MEM_SIZE                mem_size;
    } ACU_ENTRY;

endpackage

// File: rtl/address_calc_unit.sv
// rtl/address_calc_unit.sv - in-order load address queue feeding the load buffer
module address_calc_unit
    import sys_defs::*;
#(
    parameter int DEPTH = ACU_DEPTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   squash,
    input  logic                   dispatch_enable,
    input  logic                   dispatch_base_ready,
    input  logic [XLEN-1:0]        dispatch_base_value,
    input  logic [ROB_TAG_LEN-1:0] dispatch_base_tag,
    input  logic [XLEN-1:0]        dispatch_imm,
    input  logic [ROB_TAG_LEN-1:0] dispatch_rd_tag,
    input  logic [1:0]             dispatch_mem_size,
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_tag,
    input  logic [XLEN-1:0]        cdb_value,
    input  logic                   lb_full,
    output LB_PACKET               lb_packet_out,
    output logic                   alloc_enable,
    output logic                   acu_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    ACU_ENTRY               entries [DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;

    ACU_ENTRY               head_entry;
    ACU_ENTRY               new_entry;
    logic                   dispatch_accept;
    logic                   dispatch_bypass;
    logic [DEPTH-1:0]       wake;
    logic [XLEN-1:0]        head_address;

    assign head_entry   = entries[head];
    assign acu_full     = (count == FULL_COUNT);
    assign head_address = head_entry.base_value + head_entry.imm;

    assign alloc_enable    = head_entry.valid && head_entry.base_ready && !lb_full && !squash;
    assign dispatch_accept = dispatch_enable && !acu_full && !squash;
    assign dispatch_bypass = !dispatch_base_ready && cdb_valid && (cdb_tag == dispatch_base_tag);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake[i] = entries[i].valid && !entries[i].base_ready && cdb_valid
                      && (entries[i].base_tag == cdb_tag);
        end
    end

    always_comb begin
        new_entry          = '0;
        new_entry.valid    = 1'b1;
        new_entry.imm      = dispatch_imm;
        new_entry.rd_tag   = dispatch_rd_tag;
        new_entry.mem_size = MEM_SIZE'(dispatch_mem_size);
        new_entry.base_tag = dispatch_base_tag;
        if (dispatch_base_ready) begin
            new_entry.base_ready = 1'b1;
            new_entry.base_value = dispatch_base_value;
        end else if (dispatch_bypass) begin
            new_entry.base_ready = 1'b1;
            new_entry.base_value = cdb_value;
        end
    end

    // Fields are shown whenever the head holds a load; valid marks the actual allocation.
    always_comb begin
        lb_packet_out = '0;
        if (head_entry.valid) begin
            lb_packet_out.valid    = alloc_enable;
            lb_packet_out.address  = head_address;
            lb_packet_out.rd_tag   = head_entry.rd_tag;
            lb_packet_out.mem_size = head_entry.mem_size;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake[i]) begin
                    entries[i].base_ready <= 1'b1;
                    entries[i].base_value <= cdb_value;
                end
            end
            // Head and tail only coincide when empty or full, so these writes never collide.
            if (alloc_enable) begin
                entries[head] <= '0;
                head          <= head + PTR_ONE;
            end
            if (dispatch_accept) begin
                entries[tail] <= new_entry;
                tail          <= tail + PTR_ONE;
            end
            case ({dispatch_accept, alloc_enable})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_address_calc_unit.sv
// tb/tb_address_calc_unit.sv - directed vector bench for address_calc_unit
module tb_address_calc_unit;
    import sys_defs::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   squash;
    logic                   dispatch_enable;
    logic                   dispatch_base_ready;
    logic [XLEN-1:0]        dispatch_base_value;
    logic [ROB_TAG_LEN-1:0] dispatch_base_tag;
    logic [XLEN-1:0]        dispatch_imm;
    logic [ROB_TAG_LEN-1:0] dispatch_rd_tag;
    logic [1:0]             dispatch_mem_size;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic                   lb_full;
    LB_PACKET               lb_packet_out;
    logic                   alloc_enable;
    logic                   acu_full;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] base;
        logic [31:0] imm;
        logic [4:0]  rd_tag;
        logic [1:0]  size;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [6];

    address_calc_unit #(.DEPTH(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .squash              (squash),
        .dispatch_enable     (dispatch_enable),
        .dispatch_base_ready (dispatch_base_ready),
        .dispatch_base_value (dispatch_base_value),
        .dispatch_base_tag   (dispatch_base_tag),
        .dispatch_imm        (dispatch_imm),
        .dispatch_rd_tag     (dispatch_rd_tag),
        .dispatch_mem_size   (dispatch_mem_size),
        .cdb_valid           (cdb_valid),
        .cdb_tag             (cdb_tag),
        .cdb_value           (cdb_value),
        .lb_full             (lb_full),
        .lb_packet_out       (lb_packet_out),
        .alloc_enable        (alloc_enable),
        .acu_full            (acu_full)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        squash              = 1'b0;
        dispatch_enable     = 1'b0;
        dispatch_base_ready = 1'b0;
        dispatch_base_value = '0;
        dispatch_base_tag   = '0;
        dispatch_imm        = '0;
        dispatch_rd_tag     = '0;
        dispatch_mem_size   = '0;
        cdb_valid           = 1'b0;
        cdb_tag             = '0;
        cdb_value           = '0;
    endtask

    task automatic set_dispatch(input logic ready, input logic [31:0] base, input logic [4:0] btag,
                                input logic [31:0] imm, input logic [4:0] rd, input logic [1:0] size);
        dispatch_enable     = 1'b1;
        dispatch_base_ready = ready;
        dispatch_base_value = base;
        dispatch_base_tag   = btag;
        dispatch_imm        = imm;
        dispatch_rd_tag     = rd;
        dispatch_mem_size   = size;
    endtask

    task automatic check_empty(input string name);
        check({name, ".alloc"}, 64'(alloc_enable), 64'd0);
        check({name, ".pkt"}, 64'(lb_packet_out), 64'd0);
    endtask

    task automatic check_issue(input string name, input logic [4:0] rd, input logic [31:0] addr);
        check({name, ".alloc"}, 64'(alloc_enable), 64'd1);
        check({name, ".valid"}, 64'(lb_packet_out.valid), 64'd1);
        check({name, ".rd_tag"}, 64'(lb_packet_out.rd_tag), 64'(rd));
        check({name, ".addr"}, 64'(lb_packet_out.address), 64'(addr));
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 32'h0000_0004, 5'd1,  2'd2, 32'h0000_0104};
        vecs[1] = '{32'hFFFF_FFFC, 32'h0000_0008, 5'd7,  2'd0, 32'h0000_0004};
        vecs[2] = '{32'h0000_0020, 32'hFFFF_FFFC, 5'd2,  2'd1, 32'h0000_001C};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 5'd3,  2'd2, 32'h0000_0000};
        vecs[4] = '{32'h0000_1234, 32'h0000_0000, 5'd31, 2'd1, 32'h0000_1234};
        vecs[5] = '{32'h0000_0FF0, 32'h0000_0010, 5'd8,  2'd0, 32'h0000_1000};

        idle_inputs();
        lb_full = 1'b0;
        reset   = 1'b1;
        #12;
        check("reset.alloc", 64'(alloc_enable), 64'd0);
        check("reset.full", 64'(acu_full), 64'd0);
        check("reset.pkt", 64'(lb_packet_out), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Single loads back to back; six loads also walk the head pointer past its wrap.
        for (int i = 0; i < 6; i++) begin
            set_dispatch(1'b1, vecs[i].base, 5'd0, vecs[i].imm, vecs[i].rd_tag, vecs[i].size);
            tick();
            idle_inputs();
            #1;
            check_issue($sformatf("vec%0d", i), vecs[i].rd_tag, vecs[i].exp_addr);
            check($sformatf("vec%0d.size", i), 64'(lb_packet_out.mem_size), 64'(vecs[i].size));
            tick();
            #1;
            check_empty($sformatf("vec%0d.after", i));
        end

        // Not-ready head blocks a ready younger load until CDB wakeup.
        set_dispatch(1'b0, 32'h0, 5'd5, 32'hFFFF_FFFC, 5'd9, 2'd2);
        tick();
        set_dispatch(1'b1, 32'h40, 5'd0, 32'h0, 5'd3, 2'd2);
        tick();
        idle_inputs();
        #1;
        check("order.blocked", 64'(alloc_enable), 64'd0);
        tick();
        #1;
        check("order.still_blocked", 64'(alloc_enable), 64'd0);
        cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'h20;
        tick();
        idle_inputs();
        #1;
        check_issue("order.woken", 5'd9, 32'h1C);
        tick();
        #1;
        check_issue("order.younger", 5'd3, 32'h40);
        tick();
        #1;
        check_empty("order.drained");

        // Fill under lb_full, fifth dispatch dropped, then drain.
        lb_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_dispatch(1'b1, 32'h1000 + 32'(i * 4), 5'd0, 32'h0, 5'(10 + i), 2'd2);
            tick();
        end
        idle_inputs();
        #1;
        check("fill.full", 64'(acu_full), 64'd1);
        check("fill.stalled", 64'(alloc_enable), 64'd0);
        check("fill.head_tag", 64'(lb_packet_out.rd_tag), 64'd10);
        set_dispatch(1'b1, 32'h9999, 5'd0, 32'h0, 5'd14, 2'd2);
        tick();
        idle_inputs();
        #1;
        check("fill.still_full", 64'(acu_full), 64'd1);
        lb_full = 1'b0;
        #1;
        check_issue("drain0", 5'd10, 32'h1000);
        for (int i = 1; i < 4; i++) begin
            tick();
            #1;
            check($sformatf("drain%0d.full", i), 64'(acu_full), 64'd0);
            check_issue($sformatf("drain%0d", i), 5'(10 + i), 32'h1000 + 32'(i * 4));
        end
        tick();
        #1;
        check_empty("drain.dropped_fifth");

        // Full queue with same-cycle dispatch and issue: dispatch rejected.
        lb_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_dispatch(1'b1, 32'h2000, 5'd0, 32'(i), 5'(16 + i), 2'd2);
            tick();
        end
        lb_full = 1'b0;
        set_dispatch(1'b1, 32'h7777, 5'd0, 32'h0, 5'd20, 2'd2);
        tick();
        idle_inputs();
        lb_full = 1'b1;
        #1;
        check("simul.not_full", 64'(acu_full), 64'd0);
        check("simul.head_tag", 64'(lb_packet_out.rd_tag), 64'd17);
        // Dispatch-time CDB bypass into the last free slot.
        set_dispatch(1'b0, 32'h0, 5'd6, 32'h10, 5'd21, 2'd1);
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'h500;
        tick();
        idle_inputs();
        #1;
        check("simul.count3_then_full", 64'(acu_full), 64'd1);
        lb_full = 1'b0;
        #1;
        check_issue("simul.d0", 5'd17, 32'h2001);
        tick(); #1;
        check_issue("simul.d1", 5'd18, 32'h2002);
        tick(); #1;
        check_issue("simul.d2", 5'd19, 32'h2003);
        tick(); #1;
        check_issue("bypass", 5'd21, 32'h510);
        check("bypass.size", 64'(lb_packet_out.mem_size), 64'd1);
        tick(); #1;
        check_empty("bypass.drained");

        // Squash with three entries; same-cycle issue suppressed.
        lb_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_dispatch(1'b1, 32'h3000, 5'd0, 32'h0, 5'(1 + i), 2'd2);
            tick();
        end
        set_dispatch(1'b1, 32'h3100, 5'd0, 32'h0, 5'd4, 2'd2);
        squash  = 1'b1;
        lb_full = 1'b0;
        #1;
        check("squash.issue_suppressed", 64'(alloc_enable), 64'd0);
        tick();
        idle_inputs();
        #1;
        check_empty("squash.after");
        check("squash.full", 64'(acu_full), 64'd0);
        set_dispatch(1'b1, 32'h300, 5'd0, 32'h0, 5'd5, 2'd2);
        tick();
        idle_inputs();
        #1;
        check_issue("squash.redispatch", 5'd5, 32'h300);
        tick(); #1;
        check_empty("squash.redrained");

        // Async reset in the middle of a full stall.
        lb_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_dispatch(1'b1, 32'h4000, 5'd0, 32'h0, 5'(24 + i), 2'd2);
            tick();
        end
        idle_inputs();
        #1;
        check("areset.pre_full", 64'(acu_full), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("areset.full", 64'(acu_full), 64'd0);
        check_empty("areset");
        @(negedge clock);
        reset   = 1'b0;
        lb_full = 1'b0;
        set_dispatch(1'b1, 32'h44, 5'd0, 32'h0, 5'd6, 2'd0);
        tick();
        idle_inputs();
        #1;
        check_issue("areset.redispatch", 5'd6, 32'h44);
        tick(); #1;
        check_empty("areset.redrained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
